// File: rtl/fetch_decode_stage_pkg.sv
// Shared RV32I front-end definitions: opcodes, immediate-format encodings
// and the bubble word. The extender and the control unit use the same encodings.
package fetch_decode_stage_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_fmt_e;

  typedef struct packed {
    imm_fmt_e fmt;
    logic     illegal;
  } imm_dec_t;

  function automatic imm_dec_t decode_opcode(input logic [6:0] op);
    imm_dec_t d;
    d.fmt     = IMM_I;
    d.illegal = 1'b0;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR:   d.fmt = IMM_I;
      OP_STORE:                   d.fmt = IMM_S;
      OP_BRANCH:                  d.fmt = IMM_B;
      OP_JAL:                     d.fmt = IMM_J;
      OP_REG, OP_LUI, OP_AUIPC:   d.fmt = IMM_I;
      default:                    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Fetch/decode stage bus: instruction memory, hazard/redirect controls and
// the IF/ID register outputs. master = the stage, slave = its surroundings.
interface fetch_decode_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic [24:0] imm_d;
  logic [1:0]  immcntrl_d;
  logic        valid_d;
  logic        illegal_d;

  modport master (
    output imem_addr, instr_d, pc_d, pcplus4_d, imm_d, immcntrl_d, valid_d, illegal_d,
    input  imem_rdata, imem_ready, stall, redirect_e, pc_target_e
  );

  modport slave (
    input  imem_addr, instr_d, pc_d, pcplus4_d, imm_d, immcntrl_d, valid_d, illegal_d,
    output imem_rdata, imem_ready, stall, redirect_e, pc_target_e
  );
endinterface

// File: rtl/fetch_decode_stage_imm_type_decode.sv
// Combinational opcode -> immediate format / illegal-opcode flag.
module imm_type_decode
  import fetch_decode_stage_pkg::*;
(
  input  logic [6:0] i_opcode,
  output imm_fmt_e   o_immcntrl,
  output logic       o_illegal
);
  imm_dec_t w_dec;

  always_comb begin
    w_dec      = decode_opcode(i_opcode);
    o_immcntrl = w_dec.fmt;
    o_illegal  = w_dec.illegal;
  end
endmodule

// File: rtl/fetch_decode_stage.sv
// RV32I IF stage with IF/ID pipeline register: PC ownership, fetch capture,
// registered immediate-format decode, stall/redirect/wait-state handling.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_decode_stage_if.master     bus
);
  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pcplus4_d;
  imm_fmt_e    r_immcntrl_d;
  logic        r_valid_d;
  logic        r_illegal_d;

  logic [31:0] w_pcplus4_f;
  logic [31:0] w_target;
  imm_fmt_e    w_immcntrl;
  logic        w_illegal;

  assign w_pcplus4_f = r_pc_f + 32'd4;
  assign w_target    = bus.pc_target_e & ~32'd3;

  imm_type_decode u_imm_type_decode (
    .i_opcode   (bus.imem_rdata[6:0]),
    .o_immcntrl (w_immcntrl),
    .o_illegal  (w_illegal)
  );

  // Priority: redirect > stall > wait state > advance. Bubbles keep pc_d/pcplus4_d.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f       <= RESET_PC;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pcplus4_d  <= '0;
      r_immcntrl_d <= IMM_I;
      r_valid_d    <= 1'b0;
      r_illegal_d  <= 1'b0;
    end else if (bus.redirect_e) begin
      r_pc_f       <= w_target;
      r_instr_d    <= NOP_INSTR;
      r_immcntrl_d <= IMM_I;
      r_valid_d    <= 1'b0;
      r_illegal_d  <= 1'b0;
    end else if (bus.stall) begin
      r_pc_f <= r_pc_f;
    end else if (!bus.imem_ready) begin
      r_instr_d    <= NOP_INSTR;
      r_immcntrl_d <= IMM_I;
      r_valid_d    <= 1'b0;
      r_illegal_d  <= 1'b0;
    end else begin
      r_pc_f       <= w_pcplus4_f;
      r_instr_d    <= bus.imem_rdata;
      r_pc_d       <= r_pc_f;
      r_pcplus4_d  <= w_pcplus4_f;
      r_immcntrl_d <= w_immcntrl;
      r_valid_d    <= 1'b1;
      r_illegal_d  <= w_illegal;
    end
  end

  assign bus.imem_addr  = r_pc_f;
  assign bus.instr_d    = r_instr_d;
  assign bus.pc_d       = r_pc_d;
  assign bus.pcplus4_d  = r_pcplus4_d;
  assign bus.imm_d      = r_instr_d[31:7];
  assign bus.immcntrl_d = r_immcntrl_d;
  assign bus.valid_d    = r_valid_d;
  assign bus.illegal_d  = r_illegal_d;
endmodule
